// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder.
// - memop encodings (RISC-V load/store funct3)
// - responder FSM state type
// - is_legal_op(): rejects unused encodings and unsigned stores
package mem_pkg;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Unsigned variants only make sense for loads, so a store with op[2]=1
  // is illegal even though the encoding itself exists.
  function automatic logic is_legal_op(input logic [2:0] op, input logic wen);
    logic known;
    known = (op == OP_B) || (op == OP_H) || (op == OP_W) ||
            (op == OP_BU) || (op == OP_HU);
    return known && !(wen && op[2]);
  endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatter for the data-memory responder (purely combinational).
// Ports:
//   op          memop (funct3 encoding)
//   lane        byte address bits [1:0]
//   old_word    current RAM word (lanes not enabled pass through to merged_word)
//   wdata       right-aligned store data
//   raw_word    word read from RAM for loads
//   merged_word store result word, new data placed in its lane(s)
//   byte_en     per-lane write enable for the store
//   rdata       load result, sign/zero extended
//   misalign    half access at odd address or word access not 4-byte aligned
module dmem_lane_fmt
  import mem_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  lane,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [31:0] raw_word,
  output logic [31:0] merged_word,
  output logic [3:0]  byte_en,
  output logic [31:0] rdata,
  output logic        misalign
);

  logic [31:0] placed;
  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_en  = '0;
    placed   = '0;
    rdata    = '0;
    misalign = 1'b0;
    shifted  = raw_word >> {lane, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = lane[1] ? raw_word[31:16] : raw_word[15:0];
    case (op[1:0])
      2'b00: begin
        byte_en = 4'b0001 << lane;
        placed  = {4{wdata[7:0]}};
        rdata   = op[2] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      2'b01: begin
        byte_en  = lane[1] ? 4'b1100 : 4'b0011;
        placed   = {2{wdata[15:0]}};
        misalign = lane[0];
        rdata    = op[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      2'b10: begin
        byte_en  = 4'b1111;
        placed   = wdata;
        misalign = |lane;
        rdata    = raw_word;
      end
      default: begin
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_merge
      assign merged_word[gi*8 +: 8] = byte_en[gi] ? placed[gi*8 +: 8] : old_word[gi*8 +: 8];
    end
  endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: far end of the CPU data port.
// Word-organised RAM (one byte-wide array per lane) behind a valid/ready
// request channel and a valid/ready response channel with LATENCY cycles
// from request accept to resp_valid.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/req_ready       request handshake
//   req_wen, req_op           store/load and memop
//   req_addr, req_wdata       byte address, right-aligned store data
//   resp_valid/resp_ready     response handshake
//   resp_rdata                extended load data (0 for stores and errors)
//   resp_err                  misaligned, out-of-range or illegal op
module dmem_responder
  import mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int             IW       = $clog2(DEPTH_WORDS);
  localparam int             CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0]  CNT_LOAD = CW'(LATENCY - 1);
  localparam logic [32:0]    SPAN     = 33'(DEPTH_WORDS) << 2;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          wen_reg;
  logic [2:0]    op_reg;
  logic [31:0]   addr_reg;
  logic [31:0]   wdata_reg;
  logic          err_reg;
  logic          access_en;

  // The RAM access happens on the edge that enters RESP. With LATENCY=1 that
  // is the accept edge itself, so the live request is used; otherwise the
  // captured copy. In RESP the captured copy drives the load formatter.
  logic        in_idle;
  logic        acc_wen;
  logic [2:0]  acc_op;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [31:0] offset;
  logic        in_range;
  logic [IW-1:0] word_idx;
  logic        acc_err;

  assign in_idle   = (state_reg == IDLE);
  assign acc_wen   = in_idle ? req_wen   : wen_reg;
  assign acc_op    = in_idle ? req_op    : op_reg;
  assign acc_addr  = in_idle ? req_addr  : addr_reg;
  assign acc_wdata = in_idle ? req_wdata : wdata_reg;

  // Addresses below BASE_ADDR wrap to huge offsets and fail the range test.
  assign offset   = acc_addr - BASE_ADDR;
  assign in_range = ({1'b0, offset} < SPAN);
  assign word_idx = offset[IW+1:2];

  logic [31:0] merged_word;
  logic [3:0]  byte_en;
  logic [31:0] raw_word;
  logic [31:0] fmt_rdata;
  logic        misalign;

  // Writes use per-lane enables, so unselected lanes keep their contents in
  // the RAM itself and the formatter never needs the old word.
  dmem_lane_fmt u_fmt (
    .op          (acc_op),
    .lane        (acc_addr[1:0]),
    .old_word    (32'h0),
    .wdata       (acc_wdata),
    .raw_word    (raw_word),
    .merged_word (merged_word),
    .byte_en     (byte_en),
    .rdata       (fmt_rdata),
    .misalign    (misalign)
  );

  assign acc_err = !in_range || misalign || !is_legal_op(acc_op, acc_wen);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    access_en  = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cnt_next = CNT_LOAD;
          if (LATENCY == 1) begin
            state_next = RESP;
            access_en  = 1'b1;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == CW'(1)) begin
          state_next = RESP;
          access_en  = 1'b1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      wen_reg   <= 1'b0;
      op_reg    <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (req_valid && req_ready) begin
        wen_reg   <= req_wen;
        op_reg    <= req_op;
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
      end
      if (access_en) err_reg <= acc_err;
    end
  end

  // rst gates the RAM strobes so a request presented while reset is held
  // can never commit.
  logic mem_we;
  logic mem_re;
  assign mem_we = access_en && acc_wen && !acc_err && !rst;
  assign mem_re = access_en && !rst;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH_WORDS];
      logic [7:0] rd_reg;
      always_ff @(posedge clk) begin
        if (mem_we && byte_en[gi]) mem[word_idx] <= merged_word[gi*8 +: 8];
        if (mem_re) rd_reg <= mem[word_idx];
      end
      assign raw_word[gi*8 +: 8] = rd_reg;
    end
  endgenerate

  assign resp_rdata = (state_reg == RESP && !wen_reg && !err_reg) ? fmt_rdata : 32'h0;
  assign resp_err   = (state_reg == RESP) && err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // a_*: LATENCY=1 instance, b_*: LATENCY=3 instance
  logic        a_req_valid, a_req_ready, a_req_wen, a_resp_valid, a_resp_ready, a_resp_err;
  logic [2:0]  a_req_op;
  logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
  logic        b_req_valid, b_req_ready, b_req_wen, b_resp_valid, b_resp_ready, b_resp_err;
  logic [2:0]  b_req_op;
  logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;

  dmem_responder #(.BASE_ADDR(32'h8000_0000), .DEPTH_WORDS(4096), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_wen(a_req_wen),
    .req_op(a_req_op), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
  );

  dmem_responder #(.BASE_ADDR(32'h8000_0000), .DEPTH_WORDS(4096), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wen(b_req_wen),
    .req_op(b_req_op), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end else begin
      $display("ok   %s: %08h", name, act);
    end
  endtask

  function automatic logic ready_of(input bit s);
    return s ? b_req_ready : a_req_ready;
  endfunction
  function automatic logic valid_of(input bit s);
    return s ? b_resp_valid : a_resp_valid;
  endfunction
  function automatic logic [31:0] rdata_of(input bit s);
    return s ? b_resp_rdata : a_resp_rdata;
  endfunction
  function automatic logic err_of(input bit s);
    return s ? b_resp_err : a_resp_err;
  endfunction

  task automatic drive_req(input bit s, input logic v, input logic wen, input logic [2:0] op,
                           input logic [31:0] addr, input logic [31:0] wdata);
    if (s) begin
      b_req_valid = v; b_req_wen = wen; b_req_op = op; b_req_addr = addr; b_req_wdata = wdata;
    end else begin
      a_req_valid = v; a_req_wen = wen; a_req_op = op; a_req_addr = addr; a_req_wdata = wdata;
    end
  endtask

  task automatic set_rr(input bit s, input logic v);
    if (s) b_resp_ready = v;
    else   a_resp_ready = v;
  endtask

  // One full transaction: request handshake, bounded wait for the response
  // (latency measured in cycles after accept), response handshake.
  task automatic txn(input bit s, input logic wen, input logic [2:0] op, input logic [31:0] addr,
                     input logic [31:0] wdata, input int lat, input string tag,
                     output logic [31:0] rd, output logic err);
    int cyc;
    @(negedge clk);
    drive_req(s, 1'b1, wen, op, addr, wdata);
    check({tag, " req_ready"}, 32'(ready_of(s)), 32'd1);
    @(posedge clk);
    @(negedge clk);
    drive_req(s, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    cyc = 1;
    while (!valid_of(s) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'(lat));
    rd  = rdata_of(s);
    err = err_of(s);
    set_rr(s, 1'b1);
    @(negedge clk);
    set_rr(s, 1'b0);
    check({tag, " valid drop"}, 32'(valid_of(s)), 32'd0);
  endtask

  typedef struct {
    logic        wen;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  initial begin
    #200000;
    $display("FAIL global timeout: got %0d expected finish", n_vec);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        err;

    vecs[0]  = '{1'b1, OP_W,   32'h8000_0000, 32'h0BAD_F00D, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b1, OP_W,   32'h8000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[2]  = '{1'b0, OP_W,   32'h8000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[3]  = '{1'b0, OP_B,   32'h8000_0013, 32'h0,         32'hFFFF_FFDE, 1'b0};
    vecs[4]  = '{1'b0, OP_BU,  32'h8000_0013, 32'h0,         32'h0000_00DE, 1'b0};
    vecs[5]  = '{1'b0, OP_H,   32'h8000_0012, 32'h0,         32'hFFFF_DEAD, 1'b0};
    vecs[6]  = '{1'b0, OP_HU,  32'h8000_0010, 32'h0,         32'h0000_BEEF, 1'b0};
    vecs[7]  = '{1'b1, OP_B,   32'h8000_0011, 32'h0000_0055, 32'h0000_0000, 1'b0};
    vecs[8]  = '{1'b0, OP_W,   32'h8000_0010, 32'h0,         32'hDEAD_55EF, 1'b0};
    vecs[9]  = '{1'b1, OP_H,   32'h8000_0012, 32'h0000_1234, 32'h0000_0000, 1'b0};
    vecs[10] = '{1'b0, OP_W,   32'h8000_0010, 32'h0,         32'h1234_55EF, 1'b0};
    vecs[11] = '{1'b0, OP_B,   32'h8000_0010, 32'h0,         32'hFFFF_FFEF, 1'b0};
    vecs[12] = '{1'b0, OP_H,   32'h8000_0010, 32'h0,         32'h0000_55EF, 1'b0};
    vecs[13] = '{1'b0, OP_W,   32'h8000_0002, 32'h0,         32'h0000_0000, 1'b1};
    vecs[14] = '{1'b1, OP_H,   32'h8000_0001, 32'h0000_FFFF, 32'h0000_0000, 1'b1};
    vecs[15] = '{1'b0, OP_W,   32'h7FFF_FFFC, 32'h0,         32'h0000_0000, 1'b1};
    vecs[16] = '{1'b0, 3'b011, 32'h8000_0000, 32'h0,         32'h0000_0000, 1'b1};
    vecs[17] = '{1'b1, OP_BU,  32'h8000_0000, 32'h0000_00FF, 32'h0000_0000, 1'b1};
    vecs[18] = '{1'b1, OP_W,   32'h8000_4000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[19] = '{1'b0, OP_W,   32'h8000_0000, 32'h0,         32'h0BAD_F00D, 1'b0};
    vecs[20] = '{1'b1, OP_W,   32'h8000_3FFC, 32'h600D_CAFE, 32'h0000_0000, 1'b0};
    vecs[21] = '{1'b0, OP_W,   32'h8000_3FFC, 32'h0,         32'h600D_CAFE, 1'b0};
    vecs[22] = '{1'b0, OP_BU,  32'h8000_3FFF, 32'h0,         32'h0000_0060, 1'b0};
    vecs[23] = '{1'b1, 3'b111, 32'h8000_0010, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[24] = '{1'b0, OP_W,   32'h8000_0010, 32'h0,         32'h1234_55EF, 1'b0};

    rst = 1'b1;
    drive_req(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    drive_req(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    a_resp_ready = 1'b0;
    b_resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst a req_ready",  32'(a_req_ready), 32'd1);
    check("rst a resp_valid", 32'(a_resp_valid), 32'd0);
    check("rst a resp_rdata", a_resp_rdata, 32'h0);
    check("rst a resp_err",   32'(a_resp_err), 32'd0);
    check("rst b req_ready",  32'(b_req_ready), 32'd1);
    check("rst b resp_valid", 32'(b_resp_valid), 32'd0);
    rst = 1'b0;

    // LATENCY=1 table
    for (int i = 0; i < NV; i++) begin
      txn(1'b0, vecs[i].wen, vecs[i].op, vecs[i].addr, vecs[i].wdata, 1,
          $sformatf("v%0d", i), rd, err);
      check($sformatf("v%0d rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("v%0d err", i), 32'(err), 32'(vecs[i].exp_err));
    end

    // LATENCY=3: response held while resp_ready stays low, queued request
    txn(1'b1, 1'b1, OP_W, 32'h8000_0020, 32'hA5A5_0F0F, 3, "l3 sw", rd, err);
    check("l3 sw err", 32'(err), 32'd0);
    @(negedge clk);
    drive_req(1'b1, 1'b1, 1'b0, OP_W, 32'h8000_0020, 32'h0);
    check("l3 lw req_ready", 32'(b_req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    drive_req(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 3) drive_req(1'b1, 1'b1, 1'b0, OP_HU, 32'h8000_0022, 32'h0);
      check($sformatf("l3 c%0d req_ready", c), 32'(b_req_ready), 32'd0);
      check($sformatf("l3 c%0d resp_valid", c), 32'(b_resp_valid), (c >= 3) ? 32'd1 : 32'd0);
      if (c >= 3) check($sformatf("l3 c%0d rdata", c), b_resp_rdata, 32'hA5A5_0F0F);
    end
    b_resp_ready = 1'b1;
    @(negedge clk);
    b_resp_ready = 1'b0;
    check("l3 after hs resp_valid", 32'(b_resp_valid), 32'd0);
    check("l3 after hs req_ready", 32'(b_req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    drive_req(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    begin
      int cyc;
      cyc = 1;
      while (!b_resp_valid && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      check("l3 queued latency", 32'(cyc), 32'd3);
      check("l3 queued rdata", b_resp_rdata, 32'h0000_A5A5);
      check("l3 queued err", 32'(b_resp_err), 32'd0);
      b_resp_ready = 1'b1;
      @(negedge clk);
      b_resp_ready = 1'b0;
    end

    // Reset during WAIT of a store: dropped, no write
    @(negedge clk);
    drive_req(1'b1, 1'b1, 1'b1, OP_W, 32'h8000_0020, 32'h1111_2222);
    @(posedge clk);
    @(negedge clk);
    drive_req(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    check("rstw in WAIT req_ready", 32'(b_req_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("rstw req_ready",  32'(b_req_ready), 32'd1);
    check("rstw resp_valid", 32'(b_resp_valid), 32'd0);
    check("rstw resp_rdata", b_resp_rdata, 32'h0);
    check("rstw resp_err",   32'(b_resp_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    txn(1'b1, 1'b0, OP_W, 32'h8000_0020, 32'h0, 3, "rstw lw", rd, err);
    check("rstw lw rdata", rd, 32'hA5A5_0F0F);
    check("rstw lw err", 32'(err), 32'd0);
    txn(1'b0, 1'b0, OP_W, 32'h8000_0010, 32'h0, 1, "post rst l1 lw", rd, err);
    check("post rst l1 rdata", rd, 32'h1234_55EF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the far end of the CPU data port (op, address, write data, write enable out; read data back).
- Holds a word-organised RAM, decodes the 3-bit memop (RISC-V funct3 encoding), and performs byte/half/word stores and sign/zero-extended loads.
- Adds a valid/ready request channel and a valid/ready response channel with a programmable latency, so the core can later move to multi-cycle memory.
- Sits beside the CPU in the simulation top and replaces the DPI-backed memory model.

Parameters:
- BASE_ADDR, 32'h8000_0000, first byte address served.
- DEPTH_WORDS, 4096, number of 32-bit words in the RAM (power of two).
- LATENCY, 1, cycles from request accept to resp_valid (must be >= 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_wen  input  1  1 = store, 0 = load.
- req_op  input  3  memop: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- resp_valid  output  1  response present.
- resp_ready  input  1  core accepts the response.
- resp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
- resp_err  output  1  misaligned, out-of-range or illegal op.

Behaviour:
- Reset values: state IDLE; req_ready=1 after reset; resp_valid=0; resp_rdata=0; resp_err=0.
- RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. A handshake (req_valid & req_ready) captures wen, op, addr and wdata, and loads the counter with LATENCY-1.
    - If LATENCY=1, go directly to RESP.
    - Otherwise go to WAIT.
  - WAIT: req_ready=0. Decrement the counter; at 0, go to RESP.
  - RESP: resp_valid=1 and outputs are stable. On resp_ready, go to IDLE. No new request is accepted in the same cycle.
- The store commit and the load read both occur on the edge that enters RESP.
  - A load issued after a store to the same word returns the new data.
- Error conditions set resp_err=1 and suppress the write:
  - addr outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS);
  - H/HU with addr[0]=1;
  - W with addr[1:0]≠0;
  - op ∈ {011, 110, 111};
  - a store with op[2]=1.
- Word index = (addr-BASE_ADDR)>>2, truncated to log2(DEPTH_WORDS) bits. Byte lane = addr[1:0].
- Stores:
  - SB writes byte lane addr[1:0] from wdata[7:0].
  - SH writes lanes addr[1]*2 and addr[1]*2+1 from wdata[15:0].
  - SW writes all four lanes.
  - Other lanes are unchanged.
- Loads:
  - B/H sign-extend from bit 7/15 of the selected lane(s).
  - BU/HU zero-extend.
  - W returns the whole word.
- Back-to-back throughput: one transaction per LATENCY+1 cycles minimum.
- rst asserted mid-operation: the transaction is dropped, no write occurs if the state was not yet RESP, and the FSM returns to IDLE immediately.
- resp_ready while not in RESP is ignored. req_valid while req_ready=0 is ignored; the requester holds its request.

Decomposition:
- Shared package (mem_pkg):
  - memop localparams OP_B, OP_H, OP_W, OP_BU, OP_HU;
  - state enum {IDLE, WAIT, RESP};
  - function is_legal_op(op, wen).
- Sub-module dmem_lane_fmt, combinational:
  - store path: given op, addr[1:0], old word and wdata, produces merged word and byte-enable mask;
  - load path: given op, addr[1:0] and raw word, produces extended rdata;
  - also produces the misalign flag.

Test Plan:
- LATENCY=1: SW 0x8000_0010 ← 0xDEADBEEF, then LW 0x8000_0010 → resp_rdata=0xDEADBEEF, resp_err=0, resp_valid exactly 1 cycle after accept.
- Byte/half extension on word 0xDEADBEEF:
  - LB @0x...13 → 0xFFFFFFDE;
  - LBU @0x...13 → 0x000000DE;
  - LH @0x...12 → 0xFFFFDEAD;
  - LHU @0x...10 → 0x0000BEEF.
- Partial stores: SB @0x...11 ← 0x55, then LW → 0xDEAD55EF. SH @0x...12 ← 0x1234, then LW → 0x123455EF.
- Errors, each → resp_err=1, resp_rdata=0, and the word is unchanged on re-read:
  - LW @0x8000_0002;
  - SH @0x8000_0001;
  - LW @0x7FFF_FFFC;
  - op=011.
- LATENCY=3 with resp_ready held low 2 extra cycles:
  - resp_valid rises 3 cycles after accept and holds with stable data;
  - req_ready=0 throughout;
  - a new request is accepted only after the resp handshake.
- Assert rst during WAIT of an SW (LATENCY=3): outputs return to reset values asynchronously, and a subsequent LW shows the old data.
